// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4-input mux tree, with per-tenure hold timer
// and registered output capture. Define MUX4_ARB_PARK_EN to park the selects on the last owner while idle.
module mux4_rr_arbiter #(
  parameter int SIZE     = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [SIZE-1:0] mux_f,
  output logic [3:0]      gnt,
  output logic            busy,
  output logic            sel1,
  output logic            sel2,
  output logic            sel3,
  output logic [SIZE-1:0] data_out,
  output logic [1:0]      data_id,
  output logic            data_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      last_q, last_d;
  logic [7:0]      hold_q, hold_d;
  logic [3:0]      gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [2:0]      sel_q, sel_d;      // {sel3, sel2, sel1}
  logic [SIZE-1:0] data_q, data_d;
  logic [1:0]      data_id_q, data_id_d;
  logic            data_valid_q, data_valid_d;

  logic [3:0] others;
  logic       release_now;
  logic       do_grant;
  logic [1:0] pick;

  // First set bit scanning upward from (from+1) with wrap; the owner itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] idx;
    rr_pick = from;
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [2:0] sel_decode(input logic [1:0] o);
    case (o)
      2'd0:    sel_decode = 3'b101;
      2'd1:    sel_decode = 3'b100;
      2'd2:    sel_decode = 3'b010;
      default: sel_decode = 3'b000;
    endcase
  endfunction

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    hold_d      = hold_q;
    do_grant    = 1'b0;
    pick        = last_q;
    others      = req & ~(4'b0001 << owner_q);
    release_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          do_grant = 1'b1;
          pick     = rr_pick(req, last_q);
        end
      end
      GRANT: begin
        release_now = !req[owner_q] || ((hold_q == HOLD_LAST) && (others != 4'b0000));
        if (release_now) begin
          if (others != 4'b0000) begin
            do_grant = 1'b1;
            pick     = rr_pick(others, last_q);
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q == HOLD_LAST) begin
          hold_d = 8'd0;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      state_d = GRANT;
      owner_d = pick;
      last_d  = pick;
      hold_d  = 8'd0;
    end

    gnt_d  = (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;
    busy_d = (state_d == GRANT);
`ifdef MUX4_ARB_PARK_EN
    sel_d  = (state_d == GRANT) ? sel_decode(owner_d) : sel_q;
`else
    sel_d  = (state_d == GRANT) ? sel_decode(owner_d) : 3'b000;
`endif

    // The tree output reflects the selects registered on the previous edge, i.e. owner_q.
    if (busy_q) begin
      data_d       = mux_f;
      data_id_d    = owner_q;
      data_valid_d = 1'b1;
    end else begin
      data_d       = data_q;
      data_id_d    = data_id_q;
      data_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_q       <= 2'd3;
      hold_q       <= 8'd0;
      gnt_q        <= 4'b0000;
      busy_q       <= 1'b0;
      sel_q        <= 3'b000;
      data_q       <= '0;
      data_id_q    <= 2'd0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      data_id_q    <= data_id_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign sel3       = sel_q[2];
  assign sel2       = sel_q[1];
  assign sel1       = sel_q[0];
  assign data_out   = data_q;
  assign data_id    = data_id_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector table, multi-cycle sequences, and a randomized
// run against a queue-free behavioural arbiter model. Honours MUX4_ARB_PARK_EN if defined.
module tb_mux4_rr_arbiter;

  localparam int SIZE     = 8;
  localparam int MAX_HOLD = 4;
`ifdef MUX4_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [SIZE-1:0] mux_f;
  logic [3:0]      gnt;
  logic            busy, sel1, sel2, sel3;
  logic [SIZE-1:0] data_out;
  logic [1:0]      data_id;
  logic            data_valid;
  logic [SIZE-1:0] vals [4];

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.SIZE(SIZE), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mux_f(mux_f),
    .gnt(gnt), .busy(busy), .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .data_out(data_out), .data_id(data_id), .data_valid(data_valid)
  );

  // The shared mux tree itself.
  assign mux_f = sel3 ? (sel1 ? vals[0] : vals[1]) : (sel2 ? vals[2] : vals[3]);

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [2:0] sel;    // {sel3, sel2, sel1}
    logic       valid;
    logic [1:0] id;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] dec(input int o);
    case (o)
      0:       return 3'b101;
      1:       return 3'b100;
      2:       return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Round-robin rule: first set bit at (from+1), (from+2), ... mod 4.
  function automatic int rr(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return from;
  endfunction

  // Reference model state.
  int         m_owner;   // -1 when idle
  int         m_last;
  int         m_held;    // cycles the current owner has held the grant
  logic [2:0] m_sel;
  logic       m_valid;
  logic [1:0] m_id;
  logic [7:0] m_data;

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_held = 0;
    m_sel = 3'b000; m_valid = 1'b0; m_id = 2'd0; m_data = 8'd0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    logic [3:0] oth;
    if (m_owner >= 0) begin
      m_valid = 1'b1; m_id = 2'(m_owner); m_data = vals[m_owner];
    end else begin
      m_valid = 1'b0;
    end
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        m_owner = rr(r, m_last); m_last = m_owner; m_held = 1;
      end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (!r[m_owner] || (m_held >= MAX_HOLD && oth != 4'b0000)) begin
        if (oth != 4'b0000) begin
          m_owner = rr(oth, m_last); m_last = m_owner; m_held = 1;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_held = (m_held >= MAX_HOLD) ? 1 : m_held + 1;
      end
    end
    if (m_owner >= 0) m_sel = dec(m_owner);
    else if (!PARK)   m_sel = 3'b000;
  endtask

  vec_t       tbl [14];
  logic [2:0] exp_sel;
  logic [7:0] exp_data;
  logic [3:0] r;

  initial begin
    tbl[0]  = '{4'b0100, 4'b0100, 3'b010, 1'b0, 2'd0};
    tbl[1]  = '{4'b0100, 4'b0100, 3'b010, 1'b1, 2'd2};
    tbl[2]  = '{4'b0000, 4'b0000, 3'b000, 1'b1, 2'd2};
    tbl[3]  = '{4'b0000, 4'b0000, 3'b000, 1'b0, 2'd0};
    tbl[4]  = '{4'b0010, 4'b0010, 3'b100, 1'b0, 2'd0};
    tbl[5]  = '{4'b1010, 4'b0010, 3'b100, 1'b1, 2'd1};
    tbl[6]  = '{4'b1000, 4'b1000, 3'b000, 1'b1, 2'd1};
    tbl[7]  = '{4'b1000, 4'b1000, 3'b000, 1'b1, 2'd3};
    tbl[8]  = '{4'b1001, 4'b1000, 3'b000, 1'b1, 2'd3};
    tbl[9]  = '{4'b1001, 4'b1000, 3'b000, 1'b1, 2'd3};
    tbl[10] = '{4'b1001, 4'b0001, 3'b101, 1'b1, 2'd3};
    tbl[11] = '{4'b0001, 4'b0001, 3'b101, 1'b1, 2'd0};
    tbl[12] = '{4'b0000, 4'b0000, 3'b000, 1'b1, 2'd0};
    tbl[13] = '{4'b0000, 4'b0000, 3'b000, 1'b0, 2'd0};

    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3; vals[3] = 8'hD4;
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    check("rst_gnt",   32'(gnt), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_sel",   32'({sel3, sel2, sel1}), 32'h0);
    check("rst_data",  32'({data_out, data_id, data_valid}), 32'h0);
    rst_n = 1'b1;

    // Directed table.
    exp_sel  = 3'b000;
    exp_data = 8'h00;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].req);
      if (tbl[i].gnt != 4'b0000) exp_sel = tbl[i].sel;
      else if (!PARK)            exp_sel = 3'b000;
      if (tbl[i].valid)          exp_data = vals[tbl[i].id];
      check($sformatf("tbl%0d_gnt", i),   32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_busy", i),  32'(busy), 32'(tbl[i].gnt != 4'b0000));
      check($sformatf("tbl%0d_sel", i),   32'({sel3, sel2, sel1}), 32'(exp_sel));
      check($sformatf("tbl%0d_valid", i), 32'(data_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_data", i),  32'(data_out), 32'(exp_data));
      if (tbl[i].valid) check($sformatf("tbl%0d_id", i), 32'(data_id), 32'(tbl[i].id));
    end

    // Reset in the middle of a tenure drops everything at once.
    step(4'b0100);
    check("mid_gnt_before", 32'(gnt), 32'h4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt",   32'(gnt), 32'h0);
    check("mid_rst_sel",   32'({sel3, sel2, sel1}), 32'h0);
    check("mid_rst_valid", 32'({busy, data_valid}), 32'h0);
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111);
    check("post_rst_gnt",   32'(gnt), 32'h1);
    check("post_rst_sel",   32'({sel3, sel2, sel1}), 32'(dec(0)));
    check("post_rst_valid", 32'(data_valid), 32'h0);

    // A lone requester keeps the grant across timeouts.
    for (int i = 0; i < 10; i++) begin
      step(4'b0001);
      check($sformatf("solo%0d_gnt", i),  32'(gnt), 32'h1);
      check($sformatf("solo%0d_busy", i), 32'(busy), 32'h1);
    end

    // All four requesting from reset: 0,1,2,3 each for MAX_HOLD cycles, repeating.
    pulse_reset();
    for (int i = 0; i < 8 * MAX_HOLD; i++) begin
      step(4'b1111);
      check($sformatf("rot%0d_gnt", i), 32'(gnt), 32'(4'b0001 << ((i / MAX_HOLD) % 4)));
      check($sformatf("rot%0d_sel", i), 32'({sel3, sel2, sel1}), 32'(dec((i / MAX_HOLD) % 4)));
    end

    // Randomized run against the reference model.
    pulse_reset();
    model_reset();
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 5) == 0) r = 4'b0000;
      for (int j = 0; j < 4; j++) vals[j] = 8'($urandom);
      model_edge(r);
      step(r);
      check($sformatf("rnd%0d_gnt", i),
            32'({gnt, busy, sel3, sel2, sel1}),
            32'({(m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000, m_owner >= 0, m_sel}));
      check($sformatf("rnd%0d_data", i),
            32'({data_out, data_id, data_valid}), 32'({m_data, m_id, m_valid}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
